result_uart_tx: RTL
===================

# result_uart_tx

Serializer that sits downstream of the operand/result path of the calculator. It captures each completed result (9-bit magnitude plus sign) on `result_ready`, converts it to decimal ASCII, and streams the characters one byte at a time to the board UART through the `txdata`/`txclk`/`txready` handshake. Leading zeros are suppressed and a minus sign is prefixed for negative results. Its outputs drive the top-level UART transmit ports.

## Interface
- `RESULT_W`, 9: result magnitude width; fixes three decimal digits (max 511).
- `hwclk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `result_ready`  in  1  one-cycle strobe: `result` and `sign` are valid this cycle.
- `result`  in  9  unsigned magnitude to transmit.
- `sign`  in  1  1 = negative; prefixes `-`.
- `txready`  in  1  UART can accept a byte this cycle.
- `txdata`  out  8  ASCII byte; valid while `txclk` = 1.
- `txclk`  out  1  registered one-cycle byte strobe.
- `busy`  out  1  high from capture until the last byte's `txclk` cycle ends.
- `dropped`  out  1  one-cycle pulse when `result_ready` arrives while busy.

## Operation
- States: IDLE, CONVERT, SEND, DONE.
- Reset: state IDLE; `txdata` = 8'h00; `txclk`, `busy` and `dropped` = 0; capture registers cleared.
- IDLE: when `result_ready` = 1, latch `result` and `sign`, start the converter, set `busy`, and go to CONVERT.
- CONVERT:
  - Sequential double-dabble, one shift per cycle, 9 cycles.
  - Produces hundreds, tens and ones BCD digits.
  - On the done edge, builds the byte list and goes to SEND.
- Byte list, in order:
  - `-` (8'h2D) if `sign` = 1. The sign is sent even for magnitude 0.
  - Hundreds digit, only if nonzero.
  - Tens digit, if nonzero or if hundreds was sent.
  - Ones digit, always.
  - Terminator bytes (see Configuration).
  - Digits are encoded as 8'h30 + BCD.
- SEND:
  - On an edge where `txready` = 1 and `txclk` = 0, register the next byte onto `txdata`, set `txclk` = 1, and advance the pointer.
  - `txclk` always clears on the following edge, so at most one byte is issued every 2 cycles.
  - After the last byte is issued, go to DONE.
- DONE: `txclk` returns to 0; `busy` clears on the same edge; go to IDLE.
- `txdata` holds its last value when `txclk` = 0.
- `result_ready` while `busy` = 1:
  - Ignored; the transmission in progress is unaffected.
  - `dropped` pulses on the next edge.
- `result_ready` in the DONE cycle is also dropped. Capture happens only in IDLE.
- `reset` mid-transmission: immediate return to IDLE with the reset values above; a partial frame is not resumed.
- `txready` low during SEND stalls indefinitely with no byte loss; `busy` stays high.

## Timing
- Capture edge E0 is the edge where `result_ready` = 1 in IDLE. `busy` is high after E0.
- CONVERT occupies edges E1–E9.
- With `txready` held high:
  - The first `txclk` is high after E10.
  - Byte k (0-based) is high after E10+2k.
- Frame length N bytes gives the last `txclk` after E8+2N. `busy` falls after E9+2N.
- `txready` is sampled only on edges where `txclk` = 0; its value in the strobe cycle is don't-care.
- Frame lengths:
  - Minimum is 2 bytes (ones plus one terminator, with the macro undefined and positive input).
  - Maximum is 6 bytes (`-`, three digits, CR, LF).

## Configuration
- Macro `RESULT_UART_TX_CRLF_EN`.
- Defined: each frame ends with CR (8'h0D) then LF (8'h0A).
- Undefined: each frame ends with a single space (8'h20).
- Byte list length and timing follow from the chosen terminator.

## Structure
- Shared package `calc_pkg` holds:
  - the state enum `tx_state_t`;
  - ASCII constants `ASCII_ZERO`, `ASCII_MINUS`, `ASCII_CR`, `ASCII_LF`, `ASCII_SPACE`;
  - `RESULT_W`.
- One sub-module, `bin2bcd_seq`:
  - start/done handshake, 9-bit binary in, three 4-bit BCD digits out;
  - asynchronous active-high reset.
- Byte-list building and the SEND sequencing stay in `result_uart_tx`.

## Test plan
All scenarios assume the macro is defined unless stated, and `txready` = 1 unless stated.
- `result` = 123, `sign` = 0 -> bytes 31 32 33 0D 0A; first `txclk` 10 cycles after capture; strobes spaced 2 cycles apart.
- `result` = 7, `sign` = 1 -> 2D 37 0D 0A. `result` = 0, `sign` = 0 -> 30 0D 0A. `result` = 511 -> 35 31 31 0D 0A. `result` = 105 -> 31 30 35 0D 0A.
- `result` = 42 with `txready` low for 20 cycles before each byte -> same bytes 34 32 0D 0A, no extra strobes, `busy` high throughout.
- Second `result_ready` 3 cycles after capture -> one `dropped` pulse; first frame intact; no second frame.
- `reset` asserted after the second byte of 123 -> `txclk` = 0, `busy` = 0 and `txdata` = 00 immediately; the next capture of 9 sends 39 0D 0A.
- Macro undefined, `result` = 12 -> 31 32 20; `busy` falls 15 cycles after capture.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result path: transmit FSM
// states, ASCII codes, result width and the double-dabble step helper.
package calc_pkg;

   localparam int RESULT_W = 9;
   localparam int BCD_W    = 12;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_SEND    = 2'd2,
      ST_DONE    = 2'd3
   } tx_state_t;

   // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
   // the combined {bcd, bin} register left by one bit.
   function automatic logic [BCD_W+RESULT_W-1:0] dabble_step(
      input logic [BCD_W-1:0]    bcd,
      input logic [RESULT_W-1:0] bin
   );
      logic [BCD_W-1:0] adj;
      adj = bcd;
      for (int d = 0; d < 3; d++) begin
         if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      end
      return {adj, bin} << 1;
   endfunction

endpackage

// File: rtl/result_uart_tx_if.sv
// Result capture and UART byte bus between the calculator core and the
// serializer. Master = result producer / UART side, slave = result_uart_tx.
//
// Handshakes:
//  - result_ready is a one-cycle strobe; result/sign are valid only in that
//    cycle. A strobe while busy is not accepted and answered with dropped.
//  - txdata is valid only in cycles where txclk = 1; txclk is issued only on
//    an edge where txready = 1 and txclk was 0, and is always a single cycle.
interface result_uart_tx_if;
   import calc_pkg::*;

   logic                result_ready;
   logic [RESULT_W-1:0] result;
   logic                sign;
   logic                txready;
   logic [7:0]          txdata;
   logic                txclk;
   logic                busy;
   logic                dropped;
   tx_state_t           state_dbg;

   modport master (
      output result_ready, result, sign, txready,
      input  txdata, txclk, busy, dropped, state_dbg
   );

   modport slave (
      input  result_ready, result, sign, txready,
      output txdata, txclk, busy, dropped, state_dbg
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 9-bit binary to 3-digit BCD converter (double dabble).
// The first shift happens on the start edge, the remaining eight on the
// following edges; done is a registered pulse in the cycle after the last
// shift, with the digits already stable.
module bin2bcd_seq
   import calc_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [RESULT_W-1:0] bin,
   output logic                done,
   output logic [3:0]          hundreds,
   output logic [3:0]          tens,
   output logic [3:0]          ones
);

   logic [RESULT_W-1:0]       bin_q, bin_d;
   logic [BCD_W-1:0]          bcd_q, bcd_d;
   logic [3:0]                cnt_q, cnt_d;
   logic                      done_q, done_d;
   logic [BCD_W+RESULT_W-1:0] step_w;

   // Next converter state: load-and-shift on start, then shift until the count expires.
   always_comb begin
      bin_d  = bin_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      step_w = start ? dabble_step({BCD_W{1'b0}}, bin) : dabble_step(bcd_q, bin_q);
      if (start) begin
         {bcd_d, bin_d} = step_w;
         cnt_d          = 4'(RESULT_W - 1);
      end else if (cnt_q != 4'd0) begin
         {bcd_d, bin_d} = step_w;
         cnt_d          = cnt_q - 4'd1;
         done_d         = (cnt_q == 4'd1);
      end
   end

   // Converter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign done     = done_q;
   assign hundreds = bcd_q[11:8];
   assign tens     = bcd_q[7:4];
   assign ones     = bcd_q[3:0];

endmodule

// File: rtl/result_uart_tx.sv
// Captures a signed calculator result, converts it to decimal ASCII with
// leading-zero suppression and an optional '-' prefix, and streams the bytes
// over the txdata/txclk/txready UART handshake.
// Build option RESULT_UART_TX_CRLF_EN: frames end with CR LF when defined,
// with a single space otherwise.
module result_uart_tx
   import calc_pkg::*;
(
   input  logic       hwclk,
   input  logic       reset,
   result_uart_tx_if.slave bus
);

   tx_state_t  state_q, state_d;
   logic       sign_q, sign_d;
   logic       busy_q, busy_d;
   logic       dropped_q, dropped_d;
   logic       txclk_q, txclk_d;
   logic [7:0] txdata_q, txdata_d;
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] len_q, len_d;
   logic [7:0] byte_q [8];
   logic [7:0] byte_d [8];
   logic [2:0] n;

   logic       conv_start;
   logic       conv_done;
   logic [3:0] bcd_h, bcd_t, bcd_o;

   assign conv_start = (state_q == ST_IDLE) && bus.result_ready;

   bin2bcd_seq u_bcd (
      .clk      (hwclk),
      .rst      (reset),
      .start    (conv_start),
      .bin      (bus.result),
      .done     (conv_done),
      .hundreds (bcd_h),
      .tens     (bcd_t),
      .ones     (bcd_o)
   );

   // Frame FSM: capture, wait for the converter, build the byte list, send it.
   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      busy_d    = busy_q;
      txclk_d   = 1'b0;
      txdata_d  = txdata_q;
      ptr_d     = ptr_q;
      len_d     = len_q;
      byte_d    = byte_q;
      n         = 3'd0;
      // Any strobe that arrives while a frame is in flight is discarded.
      dropped_d = bus.result_ready && busy_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.result_ready) begin
               sign_d  = bus.sign;
               busy_d  = 1'b1;
               ptr_d   = 3'd0;
               state_d = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            if (conv_done) begin
               if (sign_q) begin
                  byte_d[n] = ASCII_MINUS;
                  n = n + 3'd1;
               end
               if (bcd_h != 4'd0) begin
                  byte_d[n] = ASCII_ZERO + {4'd0, bcd_h};
                  n = n + 3'd1;
               end
               if ((bcd_h != 4'd0) || (bcd_t != 4'd0)) begin
                  byte_d[n] = ASCII_ZERO + {4'd0, bcd_t};
                  n = n + 3'd1;
               end
               byte_d[n] = ASCII_ZERO + {4'd0, bcd_o};
               n = n + 3'd1;
`ifdef RESULT_UART_TX_CRLF_EN
               byte_d[n] = ASCII_CR;
               n = n + 3'd1;
               byte_d[n] = ASCII_LF;
               n = n + 3'd1;
`else
               byte_d[n] = ASCII_SPACE;
               n = n + 3'd1;
`endif
               len_d   = n;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            // txclk is forced low for a cycle after every strobe.
            if (!txclk_q && bus.txready) begin
               txdata_d = byte_q[ptr_q];
               txclk_d  = 1'b1;
               ptr_d    = ptr_q + 3'd1;
               if (ptr_q == len_q - 3'd1) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge hwclk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         sign_q    <= 1'b0;
         busy_q    <= 1'b0;
         dropped_q <= 1'b0;
         txclk_q   <= 1'b0;
         txdata_q  <= 8'h00;
         ptr_q     <= 3'd0;
         len_q     <= 3'd0;
         for (int i = 0; i < 8; i++) byte_q[i] <= 8'h00;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         busy_q    <= busy_d;
         dropped_q <= dropped_d;
         txclk_q   <= txclk_d;
         txdata_q  <= txdata_d;
         ptr_q     <= ptr_d;
         len_q     <= len_d;
         byte_q    <= byte_d;
      end
   end

   assign bus.txdata    = txdata_q;
   assign bus.txclk     = txclk_q;
   assign bus.busy      = busy_q;
   assign bus.dropped   = dropped_q;
   assign bus.state_dbg = state_q;

endmodule
